// File: rtl/coin_intake_if.sv
// Coin front-end bus: raw sensors and controls in, buffered coin code and status out.
// The slave side is the coin_intake block; the master side is whoever drives the sensors.
interface coin_intake_if;
    logic       coin5_raw;
    logic       coin10_raw;
    logic       enable;
    logic       hold;
    logic [1:0] coin_out;
    logic       reject;
    logic       fifo_full;
    logic [7:0] accept_cnt;

    modport master (
        output coin5_raw, coin10_raw, enable, hold,
        input  coin_out, reject, fifo_full, accept_cnt
    );
    modport slave (
        input  coin5_raw, coin10_raw, enable, hold,
        output coin_out, reject, fifo_full, accept_cnt
    );
endinterface

// File: rtl/coin_intake.sv
// Coin intake: per-sensor sync + debounce + rising-edge detect, coin classification,
// and a small FIFO that feeds the vending FSM one coin code per clock.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2, stable, stable_d;
    logic [CW-1:0] cnt;

    // Everything resets high so a sensor held active across reset release never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign evt = stable & ~stable_d;
endmodule

module coin_intake #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    coin_intake_if.slave  bus
);
    localparam int NUM_LANES = 2;  // lane 0 = 5rs, lane 1 = 10rs
    localparam int AW        = $clog2(FIFO_DEPTH);

    logic [NUM_LANES-1:0] raw, evt;
    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          occ, occ_nxt;
    logic                 full, push, pop, rej;
    logic [1:0]           coin_q;
    logic                 reject_q, full_q;
    logic [7:0]           accept_q;

    assign raw = {bus.coin10_raw, bus.coin5_raw};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[i]),
            .evt   (evt[i])
        );
    end

    assign full = (occ == (AW+1)'(FIFO_DEPTH));
    assign pop  = !bus.hold && (occ != '0);

    // Full check uses pre-edge occupancy, so a same-cycle pop does not rescue the coin.
    always_comb begin
        push = 1'b0;
        rej  = 1'b0;
        if (&evt) begin
            rej = 1'b1;
        end else if (|evt) begin
            if (!bus.enable || full) rej  = 1'b1;
            else                     push = 1'b1;
        end
    end

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 1'b1;
            2'b01:   occ_nxt = occ - 1'b1;
            default: occ_nxt = occ;
        endcase
    end

    // Entry bit: 0 = 5rs, 1 = 10rs. Contents need no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= evt[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            coin_q   <= 2'b00;
            reject_q <= 1'b0;
            full_q   <= 1'b0;
            accept_q <= '0;
        end else begin
            occ      <= occ_nxt;
            full_q   <= (occ_nxt == (AW+1)'(FIFO_DEPTH));
            reject_q <= rej;
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                accept_q <= accept_q + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                coin_q <= mem[rd_ptr] ? 2'b10 : 2'b01;
            end else begin
                coin_q <= 2'b00;
            end
        end
    end

    assign bus.coin_out   = coin_q;
    assign bus.reject     = reject_q;
    assign bus.fifo_full  = full_q;
    assign bus.accept_cnt = accept_q;
endmodule

// File: tb/tb_coin_intake.sv
// Directed bench for coin_intake: expected coin codes are queued as coins are inserted
// and popped as the DUT emits them; counters and status are checked at each step.
module tb_coin_intake;
    logic clk;
    logic rst_n;
    coin_intake_if bus ();

    coin_intake #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_coins = 0;
    int         rej_seen = 0;
    int         last_coin_cyc = 0;
    logic [1:0] exp_q [$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sample on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus.reject) rej_seen++;
        if (bus.coin_out !== 2'b00) begin
            n_coins++;
            last_coin_cyc = cyc;
            if (bus.hold)               chk("coin_during_hold", int'(bus.coin_out), 0);
            else if (exp_q.size() == 0) chk("unexpected_coin", int'(bus.coin_out), 0);
            else                        chk("coin_code", int'(bus.coin_out), int'(exp_q.pop_front()));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic coin(input bit ten, input int hi, input int lo);
        if (ten) bus.coin10_raw = 1'b1; else bus.coin5_raw = 1'b1;
        ticks(hi);
        bus.coin10_raw = 1'b0;
        bus.coin5_raw  = 1'b0;
        ticks(lo);
    endtask

    initial begin
        int s, c0, r0;
        rst_n          = 1'b0;
        bus.coin5_raw  = 1'b0;
        bus.coin10_raw = 1'b0;
        bus.enable     = 1'b1;
        bus.hold       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_coin_out", int'(bus.coin_out), 0);
        chk("rst_reject", int'(bus.reject), 0);
        chk("rst_fifo_full", int'(bus.fifo_full), 0);
        chk("rst_accept_cnt", int'(bus.accept_cnt), 0);
        rst_n = 1'b1;
        ticks(10);  // stable levels settle low with sensors idle

        // Single 5rs coin: code 01 seen 7 edges after the first sampling edge
        s = cyc;
        exp_q.push_back(2'b01);
        coin(1'b0, 20, 10);
        chk("t1_latency", last_coin_cyc - s - 1, 7);
        chk("t1_coins", n_coins, 1);
        chk("t1_accept", int'(bus.accept_cnt), 1);
        chk("t1_reject", rej_seen, 0);

        // Glitch shorter than the debounce window is ignored
        coin(1'b1, 2, 12);
        chk("glitch_coins", n_coins, 1);
        chk("glitch_accept", int'(bus.accept_cnt), 1);
        exp_q.push_back(2'b10);
        coin(1'b1, 10, 10);
        chk("t10_coins", n_coins, 2);
        chk("t10_accept", int'(bus.accept_cnt), 2);

        // Both sensors together: one reject, nothing queued
        bus.coin5_raw  = 1'b1;
        bus.coin10_raw = 1'b1;
        ticks(10);
        bus.coin5_raw  = 1'b0;
        bus.coin10_raw = 1'b0;
        ticks(10);
        chk("both_reject", rej_seen, 1);
        chk("both_coins", n_coins, 2);
        chk("both_accept", int'(bus.accept_cnt), 2);

        // Fill the FIFO under hold, overflow on the fifth coin
        bus.hold = 1'b1;
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        coin(1'b0, 8, 8);
        coin(1'b1, 8, 8);
        coin(1'b0, 8, 8);
        chk("fill3_full", int'(bus.fifo_full), 0);
        coin(1'b1, 8, 8);
        chk("fill4_full", int'(bus.fifo_full), 1);
        coin(1'b0, 8, 8);
        chk("ovf_reject", rej_seen, 2);
        chk("ovf_accept", int'(bus.accept_cnt), 6);
        chk("ovf_full", int'(bus.fifo_full), 1);
        c0 = n_coins;
        bus.hold = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("drain_consecutive", n_coins - c0, j);
        end
        tick();
        chk("drain_idle_out", int'(bus.coin_out), 0);
        chk("drain_full", int'(bus.fifo_full), 0);
        chk("drain_queue", exp_q.size(), 0);

        // Disabled intake rejects
        bus.enable = 1'b0;
        coin(1'b1, 8, 8);
        bus.enable = 1'b1;
        chk("dis_reject", rej_seen, 3);
        chk("dis_accept", int'(bus.accept_cnt), 6);
        chk("dis_coins", n_coins, c0 + 4);

        // Reset mid-flight discards queued coins; sensor high across release is silent
        bus.hold = 1'b1;
        coin(1'b0, 8, 8);
        coin(1'b1, 8, 8);
        chk("pre_rst_accept", int'(bus.accept_cnt), 8);
        c0 = n_coins;
        r0 = rej_seen;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_coin_out", int'(bus.coin_out), 0);
        chk("async_rst_accept", int'(bus.accept_cnt), 0);
        bus.hold      = 1'b0;
        bus.coin5_raw = 1'b1;
        @(negedge clk);
        ticks(2);
        rst_n = 1'b1;
        ticks(20);
        chk("post_rst_coins", n_coins, c0);
        chk("post_rst_accept", int'(bus.accept_cnt), 0);
        chk("post_rst_reject", rej_seen, r0);
        bus.coin5_raw = 1'b0;
        ticks(10);
        chk("post_rst_idle", int'(bus.coin_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
